// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
// Used by hazard_ctrl, hazard_ctrl_if and hazard_cmp.
package hazard_ctrl_pkg;

  localparam int HC_REG_W    = 4;
  localparam int HC_REG_ZERO = 0;

  typedef enum logic [1:0] {
    HC_RUN        = 2'd0,
    HC_LOAD_STALL = 2'd1,
    HC_FLUSH      = 2'd2,
    HC_MEM_WAIT   = 2'd3
  } hc_state_e;

  // Counter preload for a sequence of n cycles whose first cycle is the detection cycle.
  function automatic logic [2:0] hc_reload(input int n);
    return (n > 1) ? 3'(n - 2) : 3'd0;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-detection inputs and register-bank control outputs.
// The master side (hazard_ctrl) produces the bank write/flush controls.
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(
  parameter int REG_W = HC_REG_W
) ();

  logic [REG_W-1:0] decode_rs1;
  logic [REG_W-1:0] decode_rs2;
  logic             decode_uses_rs1;
  logic             decode_uses_rs2;
  logic [REG_W-1:0] execute_rd;
  logic             execute_regwrite;
  logic             execute_memread;
  logic             branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             fd_write;
  logic             de_write;
  logic             em_write;
  logic             fd_flush;
  logic             de_flush;

  modport master (
    input  decode_rs1, decode_rs2, decode_uses_rs1, decode_uses_rs2,
    input  execute_rd, execute_regwrite, execute_memread, branch_taken, mem_busy,
    output pc_write, fd_write, de_write, em_write, fd_flush, de_flush
  );

  modport slave (
    output decode_rs1, decode_rs2, decode_uses_rs1, decode_uses_rs2,
    output execute_rd, execute_regwrite, execute_memread, branch_taken, mem_busy,
    input  pc_write, fd_write, de_write, em_write, fd_flush, de_flush
  );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Combinational load-use comparator: a load in execute feeding a source read in decode.
// Register 0 is hard-wired and never creates a dependency.
module hazard_cmp import hazard_ctrl_pkg::*; #(
  parameter int REG_W = HC_REG_W
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             regwrite,
  input  logic             memread,
  output logic             lu
);

  logic rd_live;

  assign rd_live = memread & regwrite & (rd != REG_W'(HC_REG_ZERO));
  assign lu      = rd_live & ((uses_rs1 & (rs1 == rd)) | (uses_rs2 & (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-busy holds.
// Optional HAZARD_PERF_EN adds saturating stall_count / flush_count outputs.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int REG_W             = HC_REG_W,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2
) (
  input  logic          clock,
  input  logic          rst,
  hazard_ctrl_if.master bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]   stall_count,
  output logic [15:0]   flush_count
`endif
);

  localparam logic [2:0] LS_RELOAD = hc_reload(LOAD_STALL_CYCLES);
  localparam logic [2:0] FL_RELOAD = hc_reload(FLUSH_CYCLES);

  hc_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       lu;

  logic pc_w, fd_w, de_w, em_w, fd_f, de_f;
  logic eval_run, go_hold, go_branch, go_lu, stay_stall, stay_flush;

  hazard_cmp #(.REG_W(REG_W)) u_cmp (
    .rs1      (bus.decode_rs1),
    .rs2      (bus.decode_rs2),
    .uses_rs1 (bus.decode_uses_rs1),
    .uses_rs2 (bus.decode_uses_rs2),
    .rd       (bus.execute_rd),
    .regwrite (bus.execute_regwrite),
    .memread  (bus.execute_memread),
    .lu       (lu)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= HC_RUN;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pc_w       = 1'b1;
    fd_w       = 1'b1;
    de_w       = 1'b1;
    em_w       = 1'b1;
    fd_f       = 1'b0;
    de_f       = 1'b0;
    eval_run   = 1'b0;
    go_hold    = 1'b0;
    go_branch  = 1'b0;
    go_lu      = 1'b0;
    stay_stall = 1'b0;
    stay_flush = 1'b0;

    // Select an action; stall/flush sequences share the RUN branch and hold paths.
    unique case (state_q)
      HC_RUN: eval_run = 1'b1;
      HC_LOAD_STALL: begin
        if (bus.mem_busy)          go_hold   = 1'b1;
        else if (bus.branch_taken) go_branch = 1'b1;
        else                       stay_stall = 1'b1;
      end
      HC_FLUSH: begin
        if (bus.mem_busy)          go_hold   = 1'b1;
        else if (bus.branch_taken) go_branch = 1'b1;
        else                       stay_flush = 1'b1;
      end
      HC_MEM_WAIT: begin
        if (bus.mem_busy) begin
          go_hold = 1'b1;
        end else if (pend_q) begin
          go_branch = 1'b1;
          pend_d    = 1'b0;
        end else begin
          eval_run = 1'b1;
        end
      end
      default: eval_run = 1'b1;
    endcase

    if (eval_run) begin
      if (bus.mem_busy)          go_hold   = 1'b1;
      else if (bus.branch_taken) go_branch = 1'b1;
      else if (lu)               go_lu     = 1'b1;
      else                       state_d   = HC_RUN;
    end

    if (go_hold) begin
      pc_w    = 1'b0;
      fd_w    = 1'b0;
      de_w    = 1'b0;
      em_w    = 1'b0;
      state_d = HC_MEM_WAIT;
      cnt_d   = 3'd0;
      if (bus.branch_taken) pend_d = 1'b1;
    end

    if (go_branch || stay_flush) begin
      fd_f = 1'b1;
      de_f = 1'b1;
    end

    if (go_branch) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = HC_FLUSH;
        cnt_d   = FL_RELOAD;
      end else begin
        state_d = HC_RUN;
      end
    end

    if (go_lu || stay_stall) begin
      pc_w = 1'b0;
      fd_w = 1'b0;
      de_f = 1'b1;
    end

    if (go_lu) begin
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = HC_LOAD_STALL;
        cnt_d   = LS_RELOAD;
      end else begin
        state_d = HC_RUN;
      end
    end

    if (stay_stall || stay_flush) begin
      if (cnt_q == 3'd0) state_d = HC_RUN;
      else               cnt_d   = cnt_q - 3'd1;
    end
  end

  // Reset forces every bank into a held, cleared state.
  always_comb begin
    if (!rst) begin
      bus.pc_write = 1'b0;
      bus.fd_write = 1'b0;
      bus.de_write = 1'b0;
      bus.em_write = 1'b0;
      bus.fd_flush = 1'b1;
      bus.de_flush = 1'b1;
    end else begin
      bus.pc_write = pc_w;
      bus.fd_write = fd_w;
      bus.de_write = de_w;
      bus.em_write = em_w;
      bus.fd_flush = fd_f;
      bus.de_flush = de_f;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (!pc_w && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if (de_f && flush_count != 16'hFFFF)  flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic,
// expected bank controls computed by a sequence-level reference model.
module tb_hazard_ctrl;

  localparam int REG_W = 4;
  localparam int LSC   = 2;
  localparam int FC    = 2;

  localparam int A_IDLE  = 0;
  localparam int A_HOLD  = 1;
  localparam int A_BR    = 2;
  localparam int A_LU    = 3;
  localparam int A_STALL = 4;
  localparam int A_FLUSH = 5;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  hazard_ctrl_if #(.REG_W(REG_W)) bus ();

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count, flush_count;
`endif

  hazard_ctrl #(
    .REG_W             (REG_W),
    .LOAD_STALL_CYCLES (LSC),
    .FLUSH_CYCLES      (FC)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [5:0] exp_q[$];

  // Reference model: remaining cycles of the current stall/flush sequence,
  // whether the pipeline is parked on memory, and whether a branch is owed.
  int stall_rem = 0;
  int flush_rem = 0;
  bit waiting   = 0;
  bit owed      = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  task automatic drive(input logic r,
                       input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic u1, input logic u2,
                       input logic [REG_W-1:0] rd, input logic rw, input logic mr,
                       input logic br, input logic mb);
    logic [5:0] e;
    bit lu;
    int act;
    @(posedge clock);
    #1;
    rst                  = r;
    bus.decode_rs1       = rs1;
    bus.decode_rs2       = rs2;
    bus.decode_uses_rs1  = u1;
    bus.decode_uses_rs2  = u2;
    bus.execute_rd       = rd;
    bus.execute_regwrite = rw;
    bus.execute_memread  = mr;
    bus.branch_taken     = br;
    bus.mem_busy         = mb;
    cyc++;

    lu = mr && rw && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!r) begin
      e = 6'b0000_11;
      stall_rem = 0; flush_rem = 0; waiting = 0; owed = 0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (waiting && mb)                 act = A_HOLD;
      else if (waiting && owed)          begin act = A_BR; owed = 0; end
      else if (!waiting && stall_rem > 0) act = mb ? A_HOLD : (br ? A_BR : A_STALL);
      else if (!waiting && flush_rem > 0) act = mb ? A_HOLD : (br ? A_BR : A_FLUSH);
      else                               act = mb ? A_HOLD : (br ? A_BR : (lu ? A_LU : A_IDLE));

      case (act)
        A_HOLD:  begin e = 6'b0000_00; waiting = 1; owed = owed | br; stall_rem = 0; flush_rem = 0; end
        A_BR:    begin e = 6'b1111_11; waiting = 0; stall_rem = 0; flush_rem = FC - 1; end
        A_LU:    begin e = 6'b0011_01; waiting = 0; stall_rem = LSC - 1; end
        A_STALL: begin e = 6'b0011_01; stall_rem--; end
        A_FLUSH: begin e = 6'b1111_11; flush_rem--; end
        default: begin e = 6'b1111_00; waiting = 0; end
      endcase
      if (!e[5] && m_stalls < 65535) m_stalls++;
      if (e[0] && m_flushes < 65535) m_flushes++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [5:0] mon_exp, mon_got;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {bus.pc_write, bus.fd_write, bus.de_write, bus.em_write,
                 bus.fd_flush, bus.de_flush};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL bank_ctrl cyc=%0d got=%b required=%b (pc,fd,de,em,fdf,def)",
                 cyc, mon_got, mon_exp);
      end
    end
  end

  initial begin
    bus.decode_rs1 = '0; bus.decode_rs2 = '0;
    bus.decode_uses_rs1 = 0; bus.decode_uses_rs2 = 0;
    bus.execute_rd = '0; bus.execute_regwrite = 0; bus.execute_memread = 0;
    bus.branch_taken = 0; bus.mem_busy = 0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // load-use on rs2, then the same with rd=0
    drive(1, 0, 3, 0, 1, 3, 1, 1, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    idle(2);

    // branch pulse, then branch and load-use together
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    drive(1, 5, 0, 1, 0, 5, 1, 1, 1, 0);
    idle(3);

    // memory busy for 4 cycles with a branch in cycle 2
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // reset asserted mid load-stall
    drive(1, 2, 0, 1, 0, 2, 1, 1, 0, 0);
    drive(0, 2, 0, 1, 0, 2, 1, 1, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) != 0),
            REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            REG_W'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 15));
    end

`ifdef HAZARD_PERF_EN
    @(posedge clock);
    #1;
    total++;
    if (stall_count !== 16'(m_stalls)) begin
      bad++;
      $display("FAIL stall_count got=%0d required=%0d", stall_count, m_stalls);
    end
    total++;
    if (flush_count !== 16'(m_flushes)) begin
      bad++;
      $display("FAIL flush_count got=%0d required=%0d", flush_count, m_flushes);
    end
`endif

    @(negedge clock);
    @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the write-enable and flush inputs of the fetch/decode, decode/execute and execute/memory pipeline register banks.
- It is the producer side of the register-bank control interface. A bank's write input high means the bank advances. A bank's reset/flush input high means the bank loads zero.
- Detects load-use hazards, taken branches and memory-busy waits, and sequences multi-cycle stalls and flushes with a small FSM.

Parameters:
- REG_W, 4, register-specifier width (matches rd fields).
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 2, cycles de_flush stays high after a taken branch, including the detection cycle (1..7).

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- decode_rs1  in  REG_W  source 1 of the instruction in decode.
- decode_rs2  in  REG_W  source 2 of the instruction in decode.
- decode_uses_rs1  in  1  decode instruction reads rs1.
- decode_uses_rs2  in  1  decode instruction reads rs2.
- execute_rd  in  REG_W  destination of the instruction in execute.
- execute_regwrite  in  1  execute instruction writes a register.
- execute_memread  in  1  execute instruction is a load.
- branch_taken  in  1  branch resolved taken in execute (single-cycle pulse).
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- pc_write  out  1  PC register advance.
- fd_write  out  1  F/D bank advance.
- de_write  out  1  D/E bank advance.
- em_write  out  1  E/M bank advance.
- fd_flush  out  1  F/D bank clear.
- de_flush  out  1  D/E bank clear.

Behaviour:
- FSM states: RUN, LOAD_STALL, FLUSH, MEM_WAIT. 3-bit down-counter cnt. 1-bit pending_branch flag.
- Outputs are combinational from state and inputs. No added latency.
- Reset (rst low, asynchronous):
  - state=RUN, cnt=0, pending_branch=0.
  - While rst is low: all *_write=0, fd_flush=1, de_flush=1.
- Hazard term: lu = execute_memread & execute_regwrite & (execute_rd!=0) & ((decode_uses_rs1 & rs1==execute_rd) | (decode_uses_rs2 & rs2==execute_rd)). Register 0 never causes a hazard.
- Priority in RUN: mem_busy > branch_taken > lu.
- RUN, idle: all *_write=1, all flushes=0.
- RUN, mem_busy:
  - all *_write=0, flushes=0.
  - Next state MEM_WAIT.
  - If branch_taken is also high, set pending_branch=1.
- RUN, branch_taken:
  - pc_write=1 (loads the target), fd_flush=1, de_flush=1, other writes=1.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
  - lu is ignored in this cycle.
- RUN, lu:
  - pc_write=0, fd_write=0, de_flush=1, de_write=1, em_write=1.
  - If LOAD_STALL_CYCLES>1: go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-2.
- LOAD_STALL:
  - Same outputs as RUN-lu.
  - At cnt==0, return to RUN. Otherwise decrement cnt.
  - A branch_taken arriving here aborts the stall and takes the RUN-branch_taken path (outputs and next state).
  - mem_busy arriving here goes to MEM_WAIT and abandons the remaining count.
- FLUSH:
  - de_flush=1, fd_flush=1, all writes=1.
  - At cnt==0, return to RUN. Otherwise decrement cnt.
  - A new branch_taken here reloads cnt=FLUSH_CYCLES-2.
  - mem_busy here goes to MEM_WAIT.
- MEM_WAIT:
  - All writes=0, flushes=0.
  - branch_taken here sets pending_branch.
  - On the first cycle with mem_busy=0: if pending_branch, use the RUN-branch_taken outputs and transitions and clear pending_branch. Otherwise use the RUN outputs and transitions, including the lu check.
- Invariant: a bank never sees flush=1 and write=0 together, except during reset.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_count[15:0] and flush_count[15:0].
  - stall_count increments on every cycle with pc_write=0 while rst is high.
  - flush_count increments on each cycle with de_flush=1 while rst is high.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent. Control behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding constants HC_RUN=0, HC_LOAD_STALL=1, HC_FLUSH=2, HC_MEM_WAIT=3.
  - Register-0 constant.
  - The REG_W default.
- One natural sub-module: hazard_cmp, the combinational load-use comparator producing lu. It is reusable by a future forwarding unit.

Test Plan:
- Reset: rst=0 mid-stall (state LOAD_STALL) -> outputs immediately go to writes=0, flushes=1. After rst=1 with idle inputs -> all writes=1, flushes=0.
- Load-use: execute_memread=1, execute_regwrite=1, execute_rd=3, decode_rs2=3, uses_rs2=1, LOAD_STALL_CYCLES=2 -> pc_write=fd_write=0 and de_flush=1 for exactly 2 cycles, then RUN. Repeat with execute_rd=0 -> no stall.
- Branch: branch_taken pulse, FLUSH_CYCLES=2 -> fd_flush=de_flush=1 for 2 consecutive cycles, pc_write=1 throughout.
- Branch and load-use same cycle: both conditions high -> branch path wins, pc_write=1, no LOAD_STALL entry.
- Memory wait: mem_busy high 4 cycles, with a branch_taken pulse in cycle 2 -> all writes=0 for 4 cycles, then flush sequence starts the cycle mem_busy drops.
- HAZARD_PERF_EN: 3 load-use stalls of 1 cycle plus 1 branch (FLUSH_CYCLES=2) -> stall_count=3, flush_count=5.
